regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the processor's 32x32 two-read/one-write register file.
- Generalises data width, address width (depth) and read-port count.
- Adds a per-register busy scoreboard for the hazard unit: reserve at issue, release at writeback.
- Adds a sequential soft-clear engine that zeroes the array one entry per cycle without asserting reset. Sits between decode (reads, reserves) and writeback.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, address bits; DEPTH = 2**ADDR_W registers.
- NUM_READ, 2, number of independent read ports (1..4).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- ctrl_reset  in  1  synchronous, active-high reset.
- ctrl_writeEnable  in  1  writeback strobe.
- ctrl_writeReg  in  ADDR_W  writeback address.
- data_writeReg  in  DATA_W  writeback data.
- ctrl_reserveEnable  in  1  issue strobe; marks destination busy.
- ctrl_reserveReg  in  ADDR_W  destination being reserved.
- ctrl_readReg  in  NUM_READ*ADDR_W  read addresses; port p in bits [p*ADDR_W +: ADDR_W].
- data_readReg  out  NUM_READ*DATA_W  read data, same packing.
- busy_readReg  out  NUM_READ  busy flag of each addressed register.
- ctrl_clearReq  in  1  one-cycle request to start a soft clear.
- clear_busy  out  1  high while a sweep is running.

Behaviour:
Reset
- ctrl_reset high at a posedge: all registers zero, all busy bits zero, FSM to IDLE, sweep counter zero.
- Resulting outputs: data_readReg = 0, busy_readReg = 0, clear_busy = 0.
- Reset overrides every other input, including mid-sweep.

Register 0
- Always reads 0.
- Writes and reserves to register 0 are ignored; it is never busy.

Write
- At the posedge with ctrl_writeEnable=1 and ctrl_writeReg != 0: the register takes data_writeReg and its busy bit clears.

Reserve
- At the posedge with ctrl_reserveEnable=1 and ctrl_reserveReg != 0: the busy bit sets.
- Write and reserve to the same register in the same cycle: data is written and busy ends at 1 (the new producer wins).

Reads
- Combinational from the array and busy vector; no read latency.
- Without the optional feature, a written value is visible the cycle after the write edge.

FSM: IDLE / SWEEP
- IDLE, ctrl_clearReq=1 -> SWEEP, counter=0.
- SWEEP, each posedge: register[counter] <= 0, busy[counter] <= 0, counter++.
- Leave SWEEP for IDLE on the edge that clears entry DEPTH-1. A sweep lasts exactly DEPTH cycles.
- clear_busy = (state == SWEEP), registered.
- While in SWEEP:
  - ctrl_clearReq is ignored.
  - ctrl_writeEnable and ctrl_reserveEnable are ignored (dropped, not queued).
  - Reads still return current array contents; entries already swept read 0.
- Counter width ADDR_W; wraps to 0 on exit.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: write-to-read forwarding. A read port with ctrl_writeEnable=1, ctrl_writeReg == port address != 0 and state IDLE returns data_writeReg in the same cycle. Its busy_readReg shows 0 unless the same register is also being reserved that cycle.
- Undefined: no forwarding; the array value and stored busy bit are returned.

Decomposition:
- Package regfile_sb_pkg holds:
  - FSM state enum (IDLE=1'b0, SWEEP=1'b1).
  - Default width constants.
  - Function computing DEPTH from ADDR_W.
- One sub-module, regfile_sb_clear_fsm: owns state, counter and clear_busy; outputs sweep_active and sweep_addr.
- Array, scoreboard and read muxes stay in the top.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5; read r5 on port0 the next cycle -> 0xDEADBEEF; same-cycle read -> old value (bypass off) or 0xDEADBEEF (bypass on).
2. Write 0x1234 to r0, read r0 on all ports -> 0; reserve r0 -> busy_readReg 0.
3. Reserve r7 -> busy 1 next cycle; write r7 -> busy 0; reserve and write r9 in the same cycle -> busy 1, data updated.
4. Fill r1..r31 with nonzero values, pulse ctrl_clearReq -> clear_busy high for exactly 32 cycles; a write to r3 at cycle 10 is dropped; afterwards all registers read 0 and busy 0.
5. Start a sweep, assert ctrl_reset at cycle 4 -> next cycle clear_busy 0, all reads 0; a new ctrl_clearReq starts a fresh 32-cycle sweep.
6. NUM_READ=4, DATA_W=64, ADDR_W=3: four ports read distinct registers simultaneously -> correct values; sweep lasts 8 cycles.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared types and constants for the scoreboarded register file.
package regfile_sb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_READ_DEF = 2;

  // Number of registers addressable with addr_w bits.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_sb_clear_fsm.sv
// regfile_sb_clear_fsm: soft-clear sequencer. Walks the address space one
// entry per cycle after a clear request; the top zeroes the addressed entry.
module regfile_sb_clear_fsm
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              clear_req,
  output logic              sweep_active,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              clear_busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(depth_of(ADDR_W) - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count, count_nxt;

  // State and sweep counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state logic: start on request in IDLE, return after the last entry.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = SWEEP;
          count_nxt = '0;
        end
      end
      SWEEP: begin
        count_nxt = count + 1'b1;  // wraps to 0 on the final entry
        if (count == LAST) state_nxt = IDLE;
      end
    endcase
  end

  assign sweep_active = (state == SWEEP);
  assign sweep_addr   = count;
  assign clear_busy   = sweep_active;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read, single-write register file with a
// per-register busy scoreboard and a sequential soft-clear engine.
// Optional macro REGFILE_SB_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_READ = NUM_READ_DEF
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic                         ctrl_writeEnable,
  input  logic [ADDR_W-1:0]            ctrl_writeReg,
  input  logic [DATA_W-1:0]            data_writeReg,
  input  logic                         ctrl_reserveEnable,
  input  logic [ADDR_W-1:0]            ctrl_reserveReg,
  input  logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg,
  output logic [NUM_READ*DATA_W-1:0]   data_readReg,
  output logic [NUM_READ-1:0]          busy_readReg,
  input  logic                         ctrl_clearReq,
  output logic                         clear_busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              sweep_active;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_ok, rs_ok;

  regfile_sb_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .clear_req    (ctrl_clearReq),
    .sweep_active (sweep_active),
    .sweep_addr   (sweep_addr),
    .clear_busy   (clear_busy)
  );

  // Register 0 is hardwired: never written, never reserved.
  assign wr_ok = ctrl_writeEnable   && (ctrl_writeReg   != '0);
  assign rs_ok = ctrl_reserveEnable && (ctrl_reserveReg != '0);

  // Array and scoreboard update: reset, sweep zeroing, or writeback/issue.
  // NOTE: the array is reset explicitly because reset must leave every register
  // reading zero; this costs a reset path on every storage flop.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else if (sweep_active) begin
      regs[sweep_addr] <= '0;
      busy[sweep_addr] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[ctrl_writeReg] <= data_writeReg;
        busy[ctrl_writeReg] <= 1'b0;
      end
      // Later assignment wins: a same-cycle reserve leaves the register busy.
      if (rs_ok) busy[ctrl_reserveReg] <= 1'b1;
    end
  end

  // Combinational read ports.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [ADDR_W-1:0] addr;
    assign addr = ctrl_readReg[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_SB_BYPASS_EN
    logic fwd;
    assign fwd = wr_ok && !sweep_active && (addr == ctrl_writeReg);
    assign data_readReg[p*DATA_W +: DATA_W] = fwd ? data_writeReg : regs[addr];
    assign busy_readReg[p] = fwd ? (rs_ok && (ctrl_reserveReg == addr)) : busy[addr];
`else
    assign data_readReg[p*DATA_W +: DATA_W] = regs[addr];
    assign busy_readReg[p] = busy[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default and
// 4-port/64-bit/8-entry configurations).
module tb_regfile_sb;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic        rst, we, re, clr, cb;
  logic [4:0]  wr, rr;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rb;

  // Instance B: DATA_W=64, ADDR_W=3, NUM_READ=4
  logic         b_rst, b_we, b_re, b_clr, b_cb;
  logic [2:0]   b_wr, b_rr;
  logic [63:0]  b_wd;
  logic [11:0]  b_ra;
  logic [255:0] b_rd;
  logic [3:0]   b_rb;

  int checks   = 0;
  int failures = 0;

  regfile_sb dut_a (
    .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_reserveEnable(re), .ctrl_reserveReg(rr),
    .ctrl_readReg(ra), .data_readReg(rd), .busy_readReg(rb),
    .ctrl_clearReq(clr), .clear_busy(cb)
  );

  regfile_sb #(.DATA_W(64), .ADDR_W(3), .NUM_READ(4)) dut_b (
    .clock(clock), .ctrl_reset(b_rst), .ctrl_writeEnable(b_we), .ctrl_writeReg(b_wr),
    .data_writeReg(b_wd), .ctrl_reserveEnable(b_re), .ctrl_reserveReg(b_rr),
    .ctrl_readReg(b_ra), .data_readReg(b_rd), .busy_readReg(b_rb),
    .ctrl_clearReq(b_clr), .clear_busy(b_cb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int          n;
  logic [31:0] acc_d;
  logic [1:0]  acc_b;

  initial begin
    rst = 1; we = 0; re = 0; clr = 0; wr = 0; rr = 0; wd = 0; ra = 0;
    b_rst = 1; b_we = 0; b_re = 0; b_clr = 0; b_wr = 0; b_rr = 0; b_wd = 0; b_ra = 0;
    tick(); tick();
    rst = 0; b_rst = 0;

    // Reset state
    ra = {5'd3, 5'd1};
    #1;
    check("reset_data", rd, 64'd0);
    check("reset_busy", {62'd0, rb}, 64'd0);
    check("reset_clear_busy", {63'd0, cb}, 64'd0);

    // 1: write r5, same-cycle and next-cycle read
    we = 1; wr = 5; wd = 32'hDEADBEEF; ra[4:0] = 5;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check("same_cycle_r5", {32'd0, rd[31:0]}, 64'hDEADBEEF);
`else
    check("same_cycle_r5", {32'd0, rd[31:0]}, 64'd0);
`endif
    tick();
    we = 0;
    #1;
    check("next_cycle_r5", {32'd0, rd[31:0]}, 64'hDEADBEEF);

    // 2: register 0 ignores writes and reserves
    we = 1; wr = 0; wd = 32'h1234; re = 1; rr = 0; ra = 10'd0;
    #1;
    check("r0_same_cycle", rd, 64'd0);
    tick();
    we = 0; re = 0;
    #1;
    check("r0_data", rd, 64'd0);
    check("r0_busy", {62'd0, rb}, 64'd0);

    // 3: scoreboard reserve / release / same-cycle reserve+write
    re = 1; rr = 7; ra[4:0] = 7;
    tick();
    re = 0;
    #1;
    check("r7_reserved", {63'd0, rb[0]}, 64'd1);
    we = 1; wr = 7; wd = 32'd77;
    tick();
    we = 0;
    #1;
    check("r7_released", {63'd0, rb[0]}, 64'd0);
    check("r7_data", {32'd0, rd[31:0]}, 64'd77);
    re = 1; rr = 9; we = 1; wr = 9; wd = 32'd99; ra[9:5] = 9;
    tick();
    re = 0; we = 0;
    #1;
    check("r9_busy_wins", {63'd0, rb[1]}, 64'd1);
    check("r9_data", {32'd0, rd[63:32]}, 64'd99);

    // 4: fill and sweep
    for (int i = 1; i < 32; i++) begin
      we = 1; wr = 5'(i); wd = 32'h1000_0000 | 32'(i);
      tick();
    end
    we = 0;
    ra = {5'd31, 5'd3};
    #1;
    check("fill_r3", {32'd0, rd[31:0]}, 64'h1000_0003);
    check("fill_r31", {32'd0, rd[63:32]}, 64'h1000_001F);
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (cb && n < 100) begin
      we = 0; re = 0; clr = 0;
      if (n == 5) begin
        ra = {5'd20, 5'd2};
        #1;
        check("mid_sweep_unswept_r20", {32'd0, rd[63:32]}, 64'h1000_0014);
        check("mid_sweep_swept_r2", {32'd0, rd[31:0]}, 64'd0);
      end
      if (n == 10) begin
        we = 1; wr = 3; wd = 32'hBAD0_0003; re = 1; rr = 3;
      end
      if (n == 20) clr = 1;
      tick();
      n++;
    end
    we = 0; re = 0; clr = 0;
    check("sweep_len_32", 64'(n), 64'd32);
    acc_d = 0; acc_b = 0;
    for (int i = 0; i < 32; i++) begin
      ra = {5'(i), 5'(i)};
      #1;
      acc_d = acc_d | rd[31:0] | rd[63:32];
      acc_b = acc_b | rb;
    end
    check("post_sweep_data_all_zero", {32'd0, acc_d}, 64'd0);
    check("post_sweep_busy_all_zero", {62'd0, acc_b}, 64'd0);
    ra = {5'd0, 5'd3};
    #1;
    check("dropped_write_r3", {32'd0, rd[31:0]}, 64'd0);
    check("dropped_reserve_r3", {63'd0, rb[0]}, 64'd0);

    // 5: reset mid-sweep, then fresh sweep
    we = 1; wr = 12; wd = 32'h0000_ABCD;
    tick();
    we = 0;
    clr = 1;
    tick();
    clr = 0;
    tick(); tick(); tick();
    check("sweep_running_before_reset", {63'd0, cb}, 64'd1);
    rst = 1;
    tick();
    rst = 0;
    ra = {5'd12, 5'd12};
    #1;
    check("reset_mid_sweep_clear_busy", {63'd0, cb}, 64'd0);
    check("reset_mid_sweep_r12", rd, 64'd0);
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (cb && n < 100) begin
      tick();
      n++;
    end
    check("fresh_sweep_len_32", 64'(n), 64'd32);

    // 6: four-port, 64-bit, 8-entry instance
    for (int i = 1; i < 8; i++) begin
      b_we = 1; b_wr = 3'(i); b_wd = 64'h0123_4567_0000_0000 | 64'(i * 17);
      tick();
    end
    b_we = 0;
    b_re = 1; b_rr = 5;
    tick();
    b_re = 0;
    b_ra = {3'd7, 3'd2, 3'd5, 3'd1};
    #1;
    check("b_port0_r1", b_rd[63:0],    64'h0123_4567_0000_0011);
    check("b_port1_r5", b_rd[127:64],  64'h0123_4567_0000_0055);
    check("b_port2_r2", b_rd[191:128], 64'h0123_4567_0000_0022);
    check("b_port3_r7", b_rd[255:192], 64'h0123_4567_0000_0077);
    check("b_busy", {60'd0, b_rb}, 64'h2);
    b_clr = 1;
    tick();
    b_clr = 0;
    n = 0;
    while (b_cb && n < 100) begin
      tick();
      n++;
    end
    check("b_sweep_len_8", 64'(n), 64'd8);
    #1;
    check("b_post_sweep_data", {b_rd[255:192] | b_rd[191:128] | b_rd[127:64] | b_rd[63:0]}, 64'd0);
    check("b_post_sweep_busy", {60'd0, b_rb}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
